// File: rtl/fetch_pkg.sv
// Shared constants and the stored-entry type for the fetch bundle buffer.
package fetch_pkg;

  localparam int unsigned SLOT_W   = 41;
  localparam int unsigned BUNDLE_W = 128;
  localparam int unsigned SLOTS    = 6;
  localparam int unsigned TMPL_W   = 5;
  localparam int unsigned IP_HI_W  = 64 - TMPL_W;

  // One buffered bundle pair; IP bits [4:0] are implied zero.
  typedef struct packed {
    logic [IP_HI_W-1:0]      ip;
    logic [SLOTS*SLOT_W-1:0] slots;
    logic [SLOTS-1:0]        ip_mask;
    logic [SLOTS-1:0]        slot_jc;
  } fbb_entry_t;

endpackage

// File: rtl/bundle_predecode.sv
// Strips templates from a bundle pair, flags jump/call slots and builds the
// IP start mask. Purely combinational.
module bundle_predecode
  import fetch_pkg::*;
#(
  parameter logic [3:0] JC_OPC = 4'h4
) (
  input  logic [2*BUNDLE_W-1:0]   ic_bundles,
  input  logic [63:0]             ic_ip,
  output logic [SLOTS*SLOT_W-1:0] slots,
  output logic [SLOTS-1:0]        ip_mask,
  output logic [SLOTS-1:0]        slot_jc
);

  logic [1:0] slot_sel;
  logic [2:0] start;

  // Slot extraction, opcode match and start-point mask.
  always_comb begin
    slots   = '0;
    ip_mask = '0;
    slot_jc = '0;
    // Slot field 3 does not exist; treat it as the last slot of the bundle.
    slot_sel = (ic_ip[3:2] == 2'd3) ? 2'd2 : ic_ip[3:2];
    start    = (ic_ip[4] ? 3'd3 : 3'd0) + {1'b0, slot_sel};
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 3; s++) begin
        slots[(3*b+s)*SLOT_W +: SLOT_W] = ic_bundles[b*BUNDLE_W + TMPL_W + s*SLOT_W +: SLOT_W];
      end
    end
    for (int n = 0; n < SLOTS; n++) begin
      slot_jc[n] = (slots[n*SLOT_W + 37 +: 4] == JC_OPC);
      ip_mask[n] = (3'(n) >= start);
    end
  end

endmodule

// File: rtl/fetch_bundle_buffer.sv
// Fetch bundle staging FIFO: predecodes each pushed bundle pair and presents
// the head entry until downstream consumes it. branchmiss flushes everything.
// Optional feature: define FBB_BYPASS_EN to let an incoming pair reach the
// head outputs combinationally while the buffer is empty.
module fetch_bundle_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  JC_OPC = 4'h4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      branchmiss,
  input  logic                      ic_valid,
  output logic                      ic_ready,
  input  logic [63:0]               ic_ip,
  input  logic [2*BUNDLE_W-1:0]     ic_bundles,
  output logic                      phit,
  output logic [63:0]               head_ip,
  output logic [SLOTS*SLOT_W-1:0]   slots,
  output logic [SLOTS-1:0]          ip_mask,
  output logic [SLOTS-1:0]          slot_jc,
  input  logic                      slots_done,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [IP_HI_W-1:0] last_ip_q, last_ip_d;
  fbb_entry_t         mem_q [DEPTH];

  fbb_entry_t in_entry, out_entry;
  logic       bypass, push, wr_en, pop_fifo;

  bundle_predecode #(
    .JC_OPC (JC_OPC)
  ) u_predecode (
    .ic_bundles (ic_bundles),
    .ic_ip      (ic_ip),
    .slots      (in_entry.slots),
    .ip_mask    (in_entry.ip_mask),
    .slot_jc    (in_entry.slot_jc)
  );
  assign in_entry.ip = ic_ip[63:TMPL_W];

  // Handshake, head selection and pointer/count next state.
  always_comb begin
    ic_ready = (count_q < CntW'(DEPTH)) & ~branchmiss;
    push     = ic_valid & ic_ready;
    bypass   = 1'b0;
`ifdef FBB_BYPASS_EN
    bypass   = (count_q == '0) & ic_valid & ~branchmiss;
`endif
    phit     = (count_q != '0) | bypass;

    out_entry = '0;
    if (bypass) begin
      out_entry = in_entry;
    end else if (count_q != '0) begin
      out_entry = mem_q[head_q];
    end else begin
      out_entry.ip = last_ip_q;
    end
    head_ip   = {out_entry.ip, {TMPL_W{1'b0}}};
    slots     = out_entry.slots;
    ip_mask   = out_entry.ip_mask;
    slot_jc   = out_entry.slot_jc;
    last_ip_d = out_entry.ip;

    // A bypassed pair consumed in the same cycle is never written.
    wr_en    = push & ~(bypass & slots_done);
    pop_fifo = slots_done & (count_q != '0);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branchmiss) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en)    tail_d = tail_q + PtrW'(1);
      if (pop_fifo) head_d = head_q + PtrW'(1);
      case ({wr_en, pop_fifo})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign count = count_q;

  // Pointer, occupancy and held-IP registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_ip_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_ip_q <= last_ip_d;
    end
  end

  // Entry storage; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= in_entry;
  end

endmodule

// File: tb/tb_fetch_bundle_buffer.sv
// Self-checking bench for fetch_bundle_buffer (DEPTH = 4). Honors FBB_BYPASS_EN.
module tb_fetch_bundle_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0]  JC    = 4'h4;

  typedef struct packed {
    logic [58:0]  ip;
    logic [245:0] sl;
    logic [5:0]   mask;
    logic [5:0]   jc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         branchmiss = 1'b0;
  logic         ic_valid = 1'b0;
  logic         ic_ready;
  logic [63:0]  ic_ip = '0;
  logic [255:0] ic_bundles = '0;
  logic         phit;
  logic [63:0]  head_ip;
  logic [245:0] slots;
  logic [5:0]   ip_mask;
  logic [5:0]   slot_jc;
  logic         slots_done = 1'b0;
  logic [2:0]   count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ent_t mq[$];
  logic [58:0] m_last_ip = '0;

  fetch_bundle_buffer #(
    .DEPTH  (DEPTH),
    .JC_OPC (JC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .branchmiss (branchmiss),
    .ic_valid   (ic_valid),
    .ic_ready   (ic_ready),
    .ic_ip      (ic_ip),
    .ic_bundles (ic_bundles),
    .phit       (phit),
    .head_ip    (head_ip),
    .slots      (slots),
    .ip_mask    (ip_mask),
    .slot_jc    (slot_jc),
    .slots_done (slots_done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_slots(input logic [245:0] got, input logic [245:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL slots: got %h expected %h at %0t", got, exp, $time);
    end
  endtask

  // Spec-level predecode: slot n = 3*bundle + slot, templates dropped.
  function automatic ent_t model_pd(input logic [63:0] ip, input logic [255:0] b);
    ent_t r;
    int start;
    logic [40:0] s;
    start = (ip[4] ? 3 : 0) + ((ip[3:2] > 2'd2) ? 2 : int'(ip[3:2]));
    r.ip = ip[63:5];
    r.sl = '0;
    for (int n = 0; n < 6; n++) begin
      s = b[(n / 3) * 128 + 5 + (n % 3) * 41 +: 41];
      r.sl[n*41 +: 41] = s;
      r.jc[n]   = (s[40:37] == JC);
      r.mask[n] = (n >= start);
    end
    return r;
  endfunction

  // Random pair; jc_n >= 0 forces that slot to JC and all others away from it.
  function automatic logic [255:0] mk_bundles(input int jc_n);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    for (int n = 0; n < 6; n++) begin
      if (jc_n >= 0) b[(n / 3) * 128 + 5 + (n % 3) * 41 + 37 +: 4] = (n == jc_n) ? JC : 4'h0;
      else b[(n / 3) * 128 + 5 + (n % 3) * 41 + 37 +: 4] = 4'($urandom_range(0, 7));
    end
    return b;
  endfunction

  // Per-cycle compare against the queue model, then advance the model.
  always @(negedge clk) begin
    ent_t pd, e;
    bit   e_ready, e_byp, e_phit;
    if (chk_en) begin
      if (rst) begin
        mq.delete();
        m_last_ip = '0;
        chk("rst_phit", 64'(phit), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_head_ip", head_ip, 64'd0);
        chk("rst_ip_mask", 64'(ip_mask), 64'd0);
        chk("rst_slot_jc", 64'(slot_jc), 64'd0);
        chk_slots(slots, '0);
      end else begin
        pd = model_pd(ic_ip, ic_bundles);
        e_ready = (mq.size() < DEPTH) && !branchmiss;
        e_byp = 1'b0;
`ifdef FBB_BYPASS_EN
        e_byp = (mq.size() == 0) && ic_valid && !branchmiss;
`endif
        if (e_byp) begin
          e_phit = 1'b1;
          e = pd;
        end else if (mq.size() > 0) begin
          e_phit = 1'b1;
          e = mq[0];
        end else begin
          e_phit = 1'b0;
          e = '0;
          e.ip = m_last_ip;
        end
        chk("ic_ready", 64'(ic_ready), 64'(e_ready));
        chk("phit", 64'(phit), 64'(e_phit));
        chk("count", 64'(count), 64'(mq.size()));
        chk("head_ip", head_ip, {e.ip, 5'b0});
        chk("ip_mask", 64'(ip_mask), 64'(e.mask));
        chk("slot_jc", 64'(slot_jc), 64'(e.jc));
        chk_slots(slots, e.sl);
        if (branchmiss) begin
          mq.delete();
        end else if (!(e_byp && slots_done)) begin
          if (slots_done && mq.size() > 0) void'(mq.pop_front());
          if (ic_valid && e_ready) mq.push_back(pd);
        end
        m_last_ip = e.ip;
      end
    end
  end

  task automatic cyc(input bit v, input logic [63:0] ip, input logic [255:0] b,
                     input bit done, input bit bm);
    ic_valid   = v;
    ic_ip      = ip;
    ic_bundles = b;
    slots_done = done;
    branchmiss = bm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ic_valid   = 1'b0;
    slots_done = 1'b0;
    branchmiss = 1'b0;
    #1;
  endtask

  initial begin
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ic_ready", 64'(ic_ready), 64'd1);
    chk("reset_phit", 64'(phit), 64'd0);
    rst = 1'b0;
    cyc(0, '0, '0, 0, 0);

    // Single push, jump/call in bundle 1 slot 1.
    cyc(1, 64'h1000, mk_bundles(4), 0, 0);
    idle();
    chk("p1_phit", 64'(phit), 64'd1);
    chk("p1_ip_mask", 64'(ip_mask), 64'b111111);
    chk("p1_slot_jc", 64'(slot_jc), 64'b010000);
    chk("p1_head_ip", head_ip, 64'h1000);
    chk("p1_count", 64'(count), 64'd1);
    cyc(0, '0, '0, 1, 0);

    // Start-point masks.
    cyc(1, 64'h1018, mk_bundles(-1), 0, 0);
    idle();
    chk("mask_1018", 64'(ip_mask), 64'b100000);
    cyc(1, 64'h100C, mk_bundles(-1), 1, 0);
    idle();
    chk("mask_100c", 64'(ip_mask), 64'b111100);
    cyc(0, '0, '0, 1, 0);
    idle();
    chk("empty_phit", 64'(phit), 64'd0);
    chk("empty_head_ip_held", head_ip, 64'h1000);

    // Fill, refuse a 5th pair, drain in order.
    for (int i = 0; i < 4; i++) cyc(1, 64'h2000 + 64'(i) * 64'h20, mk_bundles(i), 0, 0);
    ic_valid = 1'b1;
    slots_done = 1'b1;
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(ic_ready), 64'd0);
    cyc(1, 64'h9000, mk_bundles(-1), 0, 0);
    chk("full_hold", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("drain_order", head_ip, 64'h2000 + 64'(i) * 64'h20);
      cyc(0, '0, '0, 1, 0);
    end
    idle();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_phit", 64'(phit), 64'd0);

    // Concurrent push/pop at count 2.
    cyc(1, 64'h3000, mk_bundles(-1), 0, 0);
    cyc(1, 64'h3020, mk_bundles(-1), 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 64'h3040 + 64'(i) * 64'h20, mk_bundles(-1), 1, 0);
    idle();
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_order", head_ip, 64'h3060);
    cyc(0, '0, '0, 1, 0);
    cyc(0, '0, '0, 1, 0);

    // Flush with a concurrent push at count 3.
    for (int i = 0; i < 3; i++) cyc(1, 64'h4000 + 64'(i) * 64'h20, mk_bundles(-1), 0, 0);
    cyc(1, 64'h5000, mk_bundles(-1), 0, 1);
    idle();
    chk("bm_count", 64'(count), 64'd0);
    chk("bm_phit", 64'(phit), 64'd0);

    // Empty buffer, pair offered and consumed in the same cycle.
    ic_valid = 1'b1;
    ic_ip = 64'h6000;
    ic_bundles = mk_bundles(0);
    slots_done = 1'b1;
    #1;
`ifdef FBB_BYPASS_EN
    chk("byp_phit", 64'(phit), 64'd1);
    chk("byp_head_ip", head_ip, 64'h6000);
`else
    chk("byp_phit", 64'(phit), 64'd0);
`endif
    @(posedge clk);
    #1;
    idle();
`ifdef FBB_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("byp_count", 64'(count), 64'd1);
`endif
    cyc(0, '0, '0, 1, 0);

    // Asynchronous reset mid-operation.
    cyc(1, 64'h7000, mk_bundles(-1), 0, 0);
    cyc(1, 64'h7020, mk_bundles(-1), 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_phit", 64'(phit), 64'd0);
    chk("arst_head_ip", head_ip, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, '0, '0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) < 6, {$urandom, $urandom}, mk_bundles(-1),
          $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
    end
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
